player_cmd_arbiter: RTL and testbench

- Sits between the keyboard command decoder and the game-logic FSM.
- Takes two per-player command pulse streams: P1 from the letter keys, P2 from the arrow keys.
- Buffers each stream in a small FIFO, drops attack commands that arrive during a per-player cooldown, and round-robin arbitrates the two players onto one valid/ready action port.
- Command encoding: LEFT=0, RIGHT=1, DOWN=2, UP=3, ENTER=4, PUNCH=5, GARD=6, KICK=7, idle=4'hF.

---
 rtl/player_cmd_arbiter_if.sv | 11 +
 rtl/player_cmd_arbiter.sv | 139 +++++++++++++
 tb/tb_player_cmd_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/player_cmd_arbiter_if.sv
// Action port from the command arbiter to the game-logic FSM.
// The arbiter drives the action; the consumer answers with out_ready.
interface player_cmd_arbiter_if;
  logic       out_valid;
  logic       out_ready;
  logic       out_player;
  logic [3:0] out_cmd;

  modport master (output out_valid, output out_player, output out_cmd, input out_ready);
  modport slave  (input out_valid, input out_player, input out_cmd, output out_ready);
endinterface

// File: rtl/player_cmd_arbiter.sv
// Per-player command FIFOs with attack cooldown filtering, round-robin
// merged onto a single registered valid/ready action port.
// Index 0 is P1 (letter keys), index 1 is P2 (arrow keys).
module player_cmd_arbiter #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned COOLDOWN = 5000000,
  parameter int unsigned CD_W     = 23
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [3:0]                  p1_cmd,
  input  logic [3:0]                  p2_cmd,
  input  logic                        flush,
  player_cmd_arbiter_if.master        act,
  output logic                        p1_busy,
  output logic                        p2_busy,
  output logic                        p1_drop,
  output logic                        p2_drop
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [3:0]      mem     [2][DEPTH];
  logic [AW-1:0]   wr_ptr  [2];
  logic [AW-1:0]   rd_ptr  [2];
  logic [CNT_W-1:0] count  [2];
  logic [CD_W-1:0] cd_cnt  [2];
  logic [3:0]      cmd_in  [2];

  logic [1:0] busy, drop;
  logic [1:0] cand, attack, blocked, fits, push, pop, drop_next;
  logic       last_grant;
  logic       grant;
  logic       stage_free;
  logic       do_pop;

  assign p1_busy = busy[0];
  assign p2_busy = busy[1];
  assign p1_drop = drop[0];
  assign p2_drop = drop[1];

  // Classify inputs, pick the arbitration winner and decide pushes/drops.
  always_comb begin
    cmd_in[0]  = p1_cmd;
    cmd_in[1]  = p2_cmd;
    stage_free = !act.out_valid || act.out_ready;
    // Both non-empty: alternate; otherwise grant whichever is non-empty.
    if (count[0] != '0 && count[1] != '0) grant = ~last_grant;
    else                                  grant = (count[0] == '0);
    do_pop = !flush && stage_free && (count[0] != '0 || count[1] != '0);
    pop[0] = do_pop && !grant;
    pop[1] = do_pop && grant;
    for (int unsigned p = 0; p < 2; p++) begin
      cand[p]      = !cmd_in[p][3];
      attack[p]    = (cmd_in[p] == 4'd5) || (cmd_in[p] == 4'd7);
      blocked[p]   = attack[p] && (cd_cnt[p] != '0);
      // A full FIFO still accepts when its head leaves in the same cycle.
      fits[p]      = (count[p] != CNT_W'(DEPTH)) || pop[p];
      push[p]      = !flush && cand[p] && !blocked[p] && fits[p];
      drop_next[p] = !flush && cand[p] && !push[p];
    end
  end

  // FIFO storage; contents need no reset since pointers and counts gate reads.
  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < 2; p++) begin
      if (push[p]) mem[p][wr_ptr[p]] <= cmd_in[p];
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned p = 0; p < 2; p++) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
        count[p]  <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < 2; p++) begin
        if (flush) begin
          wr_ptr[p] <= '0;
          rd_ptr[p] <= '0;
          count[p]  <= '0;
        end else begin
          if (push[p]) wr_ptr[p] <= wr_ptr[p] + AW'(1);
          if (pop[p])  rd_ptr[p] <= rd_ptr[p] + AW'(1);
          case ({push[p], pop[p]})
            2'b10:   count[p] <= count[p] + CNT_W'(1);
            2'b01:   count[p] <= count[p] - CNT_W'(1);
            default: count[p] <= count[p];
          endcase
        end
      end
    end
  end

  // Attack cooldown counters, busy flags and registered drop pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned p = 0; p < 2; p++) cd_cnt[p] <= '0;
      busy <= '0;
      drop <= '0;
    end else begin
      for (int unsigned p = 0; p < 2; p++) begin
        if (push[p] && attack[p])  cd_cnt[p] <= CD_W'(COOLDOWN - 1);
        else if (cd_cnt[p] != '0)  cd_cnt[p] <= cd_cnt[p] - CD_W'(1);
        // Busy rises the cycle after the accepting edge, even for COOLDOWN=1.
        busy[p] <= (push[p] && attack[p]) || (cd_cnt[p] != '0);
      end
      drop <= drop_next;
    end
  end

  // Output stage register and round-robin history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act.out_valid  <= 1'b0;
      act.out_player <= 1'b0;
      act.out_cmd    <= 4'hF;
      last_grant     <= 1'b1;
    end else if (flush) begin
      act.out_valid <= 1'b0;
      act.out_cmd   <= 4'hF;
    end else if (stage_free) begin
      if (do_pop) begin
        act.out_valid  <= 1'b1;
        act.out_player <= grant;
        act.out_cmd    <= mem[grant][rd_ptr[grant]];
        last_grant     <= grant;
      end else begin
        act.out_valid <= 1'b0;
        act.out_cmd   <= 4'hF;
      end
    end
  end

endmodule

// File: tb/tb_player_cmd_arbiter.sv
// Self-checking bench for player_cmd_arbiter: directed scenarios followed by
// random traffic, all compared cycle by cycle against a queue-based model.
module tb_player_cmd_arbiter;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned COOLDOWN = 8;
  localparam int unsigned CD_W     = 4;

  logic       clk;
  logic       rst;
  logic [3:0] p1_cmd, p2_cmd;
  logic       flush;
  logic       p1_busy, p2_busy, p1_drop, p2_drop;

  player_cmd_arbiter_if bus ();

  player_cmd_arbiter #(
    .DEPTH    (DEPTH),
    .COOLDOWN (COOLDOWN),
    .CD_W     (CD_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .p1_cmd  (p1_cmd),
    .p2_cmd  (p2_cmd),
    .flush   (flush),
    .act     (bus.master),
    .p1_busy (p1_busy),
    .p2_busy (p2_busy),
    .p1_drop (p1_drop),
    .p2_drop (p2_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state
  logic [3:0] q0[$];
  logic [3:0] q1[$];
  bit         m_valid  = 1'b0;
  bit         m_player = 1'b0;
  logic [3:0] m_cmd    = 4'hF;
  bit         m_last   = 1'b1;
  bit         m_drop [2] = '{1'b0, 1'b0};
  int         acc_cyc [2] = '{-100, -100};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Offer one command to player p's queue; s is the pre-edge occupancy.
  task automatic accept(input int p, input logic [3:0] c, input int s, input bit popped,
                        output bit dropped);
    bit is_attack;
    dropped   = 1'b0;
    is_attack = (c == 4'd5) || (c == 4'd7);
    if (c >= 4'd8) begin
      dropped = 1'b0;
    end else if (is_attack && cyc < acc_cyc[p] + int'(COOLDOWN)) begin
      dropped = 1'b1;
    end else if (s < int'(DEPTH) || popped) begin
      if (p == 0) q0.push_back(c); else q1.push_back(c);
      if (is_attack) acc_cyc[p] = cyc;
    end else begin
      dropped = 1'b1;
    end
  endtask

  // Advance the model by one clock edge given the inputs of cycle 'cyc'.
  task automatic model_edge(input logic [3:0] c1, input logic [3:0] c2, input bit rdy, input bit fl);
    int s0, s1;
    bit pop0, pop1, g, d0, d1;
    s0 = q0.size();
    s1 = q1.size();
    pop0 = 1'b0;
    pop1 = 1'b0;
    if (fl) begin
      q0.delete();
      q1.delete();
      m_valid = 1'b0;
      m_cmd   = 4'hF;
      m_drop  = '{1'b0, 1'b0};
    end else begin
      if (!m_valid || rdy) begin
        if (s0 > 0 || s1 > 0) begin
          g = (s0 > 0 && s1 > 0) ? !m_last : (s0 == 0);
          m_last   = g;
          m_valid  = 1'b1;
          m_player = g;
          if (g == 1'b0) begin m_cmd = q0.pop_front(); pop0 = 1'b1; end
          else           begin m_cmd = q1.pop_front(); pop1 = 1'b1; end
        end else begin
          m_valid = 1'b0;
          m_cmd   = 4'hF;
        end
      end
      accept(0, c1, s0, pop0, d0);
      accept(1, c2, s1, pop1, d1);
      m_drop = '{d0, d1};
    end
  endtask

  function automatic bit exp_busy(input int p);
    return (cyc > acc_cyc[p]) && (cyc <= acc_cyc[p] + int'(COOLDOWN));
  endfunction

  task automatic compare_all();
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("out_cmd",   32'(bus.out_cmd),   32'(m_cmd));
    if (m_valid) check("out_player", 32'(bus.out_player), 32'(m_player));
    check("p1_busy", 32'(p1_busy), 32'(exp_busy(0)));
    check("p2_busy", 32'(p2_busy), 32'(exp_busy(1)));
    check("p1_drop", 32'(p1_drop), 32'(m_drop[0]));
    check("p2_drop", 32'(p2_drop), 32'(m_drop[1]));
  endtask

  task automatic step(input logic [3:0] c1, input logic [3:0] c2, input bit rdy, input bit fl);
    p1_cmd        = c1;
    p2_cmd        = c2;
    bus.out_ready = rdy;
    flush         = fl;
    @(posedge clk);
    model_edge(c1, c2, rdy, fl);
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(4'hF, 4'hF, rdy, 1'b0);
  endtask

  function automatic logic [3:0] rand_cmd();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 50)      return 4'hF;
    else if (r < 56) return 4'($urandom_range(8, 14));
    else if (r < 70) return (r < 63) ? 4'd5 : 4'd7;
    else             return 4'($urandom_range(0, 7));
  endfunction

  initial begin
    rst           = 1'b0;
    p1_cmd        = 4'hF;
    p2_cmd        = 4'hF;
    flush         = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst_out_valid",  32'(bus.out_valid),  32'd0);
    check("rst_out_cmd",    32'(bus.out_cmd),    32'hF);
    check("rst_out_player", 32'(bus.out_player), 32'd0);
    check("rst_busy",       32'({p1_busy, p2_busy}), 32'd0);
    check("rst_drop",       32'({p1_drop, p2_drop}), 32'd0);
    rst = 1'b1;

    // Idle after reset
    idle(20, 1'b1);

    // PUNCH, an early KICK that is filtered, then a KICK after cooldown
    step(4'd5, 4'hF, 1'b1, 1'b0);
    step(4'hF, 4'hF, 1'b1, 1'b0);
    check("punch_out_cmd", 32'(bus.out_cmd), 32'd5);
    check("punch_busy",    32'(p1_busy),     32'd1);
    step(4'hF, 4'hF, 1'b1, 1'b0);
    step(4'd7, 4'hF, 1'b1, 1'b0);
    check("kick_drop", 32'(p1_drop), 32'd1);
    idle(6, 1'b1);
    step(4'd7, 4'hF, 1'b1, 1'b0);
    idle(12, 1'b1);

    // Simultaneous inputs from both players, interleaved on the output
    step(4'd0, 4'd1, 1'b1, 1'b0);
    step(4'd2, 4'd3, 1'b1, 1'b0);
    idle(6, 1'b1);

    // Stalled consumer: stage plus FIFO fill, sixth GARD dropped
    for (int i = 0; i < 6; i++) step(4'hF, 4'd6, 1'b0, 1'b0);
    check("stall_drop", 32'(p2_drop), 32'd1);
    check("stall_cmd",  32'(bus.out_cmd), 32'd6);
    idle(3, 1'b0);
    idle(8, 1'b1);

    // Flush with entries queued on both sides
    step(4'd0, 4'd1, 1'b0, 1'b0);
    step(4'd2, 4'd3, 1'b0, 1'b0);
    step(4'd4, 4'd6, 1'b0, 1'b0);
    step(4'd1, 4'd0, 1'b0, 1'b1);
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    check("flush_cmd",   32'(bus.out_cmd),   32'hF);
    idle(5, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(rand_cmd(), rand_cmd(), ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 2));
    end
    idle(10, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
